ext_bus_multiplexer: RTL and testbench

EXT_BUS_MULTIPLEXER -- requirements
Module: ext_bus_multiplexer

---
 rtl/ext_bus_multiplexer_pkg.sv | 40 ++++
 rtl/ext_bus_multiplexer_if.sv | 25 ++
 rtl/ext_bus_multiplexer_sel_sync.sv | 44 ++++
 rtl/ext_bus_multiplexer.sv | 98 +++++++++
 tb/tb_ext_bus_multiplexer.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/ext_bus_multiplexer_pkg.sv
// Shared encodings and constants for the external byte-lane multiplexer.
package ext_bus_multiplexer_pkg;

    typedef enum logic [1:0] {
        SEL_ADDR_LO = 2'b00,
        SEL_ADDR_HI = 2'b01,
        SEL_DATA    = 2'b10,
        SEL_RELEASE = 2'b11
    } sel_e;

    // Consecutive readback mismatches that latch the conflict flag
    localparam int MISMATCH_THRESH = 2;
    localparam int CNT_W           = 2;

    // Lane turnaround sequencing: data is loaded one clock before the
    // enable rises, and the enable drops before the data is cleared.
    typedef enum logic [1:0] {
        ST_RELEASED = 2'b00,
        ST_LOADING  = 2'b01,
        ST_DRIVING  = 2'b10
    } lane_state_e;

    // Byte presented on the lane for a given select code
    function automatic logic [7:0] lane_byte(
        input sel_e        sel,
        input logic [15:0] cpu_addr,
        input logic [7:0]  cpu_data
    );
        logic [7:0] b;
        b = 8'h00;
        case (sel)
            SEL_ADDR_LO: b = cpu_addr[7:0];
            SEL_ADDR_HI: b = cpu_addr[15:8];
            SEL_DATA:    b = cpu_data;
            default:     b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ext_bus_multiplexer_if.sv
// Lane/bus signal bundle between the multiplexer and its surroundings.
interface ext_bus_multiplexer_if;
    import ext_bus_multiplexer_pkg::*;

    logic [1:0]  i_sel;
    logic [15:0] i_cpu_addr;
    logic [7:0]  i_cpu_data;
    logic [7:0]  i_mux_data;
    logic [7:0]  o_mux_data;
    logic        o_mux_data_oe;
    logic        o_bus_conflict;

    // Environment side: drives select, CPU buses and pad readback
    modport master (
        output i_sel, i_cpu_addr, i_cpu_data, i_mux_data,
        input  o_mux_data, o_mux_data_oe, o_bus_conflict
    );

    // Multiplexer side
    modport slave (
        input  i_sel, i_cpu_addr, i_cpu_data, i_mux_data,
        output o_mux_data, o_mux_data_oe, o_bus_conflict
    );

endinterface

// File: rtl/ext_bus_multiplexer_sel_sync.sv
// Two-flop synchronizer for the asynchronous select plus a stability
// qualifier: a code is accepted only after two equal synchronized samples.
module ext_bus_multiplexer_sel_sync
    import ext_bus_multiplexer_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [1:0] sel_i,
    output logic [1:0] sel_s3_o,
    output sel_e       sel_acc_o,
    output sel_e       sel_acc_nxt_o
);

    logic [1:0] s1_q, s2_q, s3_q;
    sel_e       acc_q, acc_d;

    // Accept s2 only when it agrees with the sample one clock older
    always_comb begin
        acc_d = acc_q;
        if (s2_q == s3_q) begin
            acc_d = sel_e'(s2_q);
        end
    end

    // Synchronizer chain and accepted-select register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            s1_q  <= SEL_RELEASE;
            s2_q  <= SEL_RELEASE;
            s3_q  <= SEL_RELEASE;
            acc_q <= SEL_RELEASE;
        end else begin
            s1_q  <= sel_i;
            s2_q  <= s1_q;
            s3_q  <= s2_q;
            acc_q <= acc_d;
        end
    end

    assign sel_s3_o      = s3_q;
    assign sel_acc_o     = acc_q;
    assign sel_acc_nxt_o = acc_d;

endmodule

// File: rtl/ext_bus_multiplexer.sv
// Shared byte-lane multiplexer: drives one of three CPU bytes (or releases
// the lane) as chosen by an external asynchronous select, sequences the
// output enable around data changes, and latches a readback conflict flag.
//
// state       | meaning
// ST_RELEASED | lane not driven (oe=0)
// ST_LOADING  | driven byte registered, enable rises next clock
// ST_DRIVING  | lane driven (oe=1)
module ext_bus_multiplexer
    import ext_bus_multiplexer_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    ext_bus_multiplexer_if.slave  bus
);

    logic [1:0]       sel_s3;
    sel_e             sel_acc;
    sel_e             sel_acc_nxt;

    lane_state_e      st_q, st_d;
    logic [7:0]       data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flag_q, flag_d;
    logic             oe;

    ext_bus_multiplexer_sel_sync u_sel_sync (
        .clk_i         (i_clk),
        .rst_n_i       (i_reset_n),
        .sel_i         (bus.i_sel),
        .sel_s3_o      (sel_s3),
        .sel_acc_o     (sel_acc),
        .sel_acc_nxt_o (sel_acc_nxt)
    );

    // Lane sequencing state register
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            st_q <= ST_RELEASED;
        end else begin
            st_q <= st_d;
        end
    end

    // Next state: a pending release drops the enable in the same clock the
    // release is accepted; turning on waits for the data to be loaded first.
    always_comb begin
        st_d = st_q;
        if (sel_acc_nxt == SEL_RELEASE) begin
            st_d = ST_RELEASED;
        end else begin
            case (st_q)
                ST_RELEASED: if (sel_acc != SEL_RELEASE) st_d = ST_LOADING;
                ST_LOADING:  st_d = ST_DRIVING;
                ST_DRIVING:  st_d = ST_DRIVING;
                default:     st_d = ST_RELEASED;
            endcase
        end
    end

    assign oe = (st_q == ST_DRIVING);

    // Output data, mismatch counter and sticky conflict flag next values
    always_comb begin
        data_d = lane_byte(sel_acc, bus.i_cpu_addr, bus.i_cpu_data);
        cnt_d  = cnt_q;
        if (!oe) begin
            cnt_d = '0;
        end else if (sel_acc == sel_e'(sel_s3)) begin
            if (bus.i_mux_data != data_q) begin
                if (cnt_q < CNT_W'(MISMATCH_THRESH)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = '0;
            end
        end
        flag_d = flag_q | (cnt_d >= CNT_W'(MISMATCH_THRESH));
    end

    // Registered lane data and conflict tracking
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            data_q <= 8'h00;
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
        end
    end

    assign bus.o_mux_data     = data_q;
    assign bus.o_mux_data_oe  = oe;
    assign bus.o_bus_conflict = flag_q;

endmodule

// File: tb/tb_ext_bus_multiplexer.sv
// Directed bench for ext_bus_multiplexer with a history-based reference model.
module tb_ext_bus_multiplexer;

    logic clk = 1'b0;
    logic rst_n;
    bit   bad;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ext_bus_multiplexer_if bus ();

    // Pad loopback: the lane reads back what is driven unless a fault is forced
    assign bus.i_mux_data = bad ? 8'hFF : bus.o_mux_data;

    ext_bus_multiplexer dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] exp_byte(input int s, input logic [15:0] a,
                                            input logic [7:0] d);
        case (s)
            0:       return a[7:0];
            1:       return a[15:8];
            2:       return d;
            default: return 8'h00;
        endcase
    endfunction

    // inputs as seen at the previous falling edge (stable across the rising edge)
    logic        in_rst_n = 1'b0;
    int          in_sel = 3;
    logic [15:0] in_addr = '0;
    logic [7:0]  in_data = '0;
    logic [7:0]  in_mux = '0;

    int          sh [3];   // raw select samples, [0] newest
    int          ah [3];   // accepted select after each of the last 3 edges
    logic [7:0]  m_data;
    bit          m_oe, m_flag, m_valid = 0;
    int          m_cnt;
    int          acc_new;
    logic [7:0]  d_new;

    always @(posedge clk) begin
        if (!in_rst_n) begin
            sh = '{3, 3, 3};
            ah = '{3, 3, 3};
            m_data = 8'h00; m_oe = 0; m_cnt = 0; m_flag = 0; m_valid = 1;
        end else begin
            acc_new = (sh[1] == sh[2]) ? sh[1] : ah[0];
            if (!m_oe) m_cnt = 0;
            else if (ah[0] == sh[2]) m_cnt = (in_mux != m_data) ? m_cnt + 1 : 0;
            if (m_cnt >= 2) m_flag = 1;
            d_new = exp_byte(ah[0], in_addr, in_data);
            sh[2] = sh[1]; sh[1] = sh[0]; sh[0] = in_sel;
            ah[2] = ah[1]; ah[1] = ah[0]; ah[0] = acc_new;
            m_data = d_new;
            m_oe = (ah[0] != 3) && (ah[1] != 3) && (ah[2] != 3);
        end
    end

    // Per-cycle comparison against the model, then input capture
    always @(negedge clk) begin
        if (m_valid) begin
            n_cmp++;
            if (bus.o_mux_data !== m_data || bus.o_mux_data_oe !== m_oe ||
                bus.o_bus_conflict !== m_flag) begin
                n_bad++;
                $display("FAIL model t=%0t data=%h/%h oe=%b/%b flag=%b/%b (got/exp)",
                         $time, bus.o_mux_data, m_data, bus.o_mux_data_oe, m_oe,
                         bus.o_bus_conflict, m_flag);
            end
        end
        in_rst_n = rst_n;
        in_sel   = int'(bus.i_sel);
        in_addr  = bus.i_cpu_addr;
        in_data  = bus.i_cpu_data;
        in_mux   = bus.i_mux_data;
    end

    // ---------------- directed stimulus ----------------
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; bad = 0;
        bus.i_sel = 2'b11; bus.i_cpu_addr = 16'h0000; bus.i_cpu_data = 8'h00;
        step(3);
        rst_n = 1'b1;
        step(5);
        chk("reset_oe",   {7'd0, bus.o_mux_data_oe}, 8'h00);
        chk("reset_data", bus.o_mux_data, 8'h00);
        chk("reset_flag", {7'd0, bus.o_bus_conflict}, 8'h00);

        // released -> low address byte
        bus.i_cpu_addr = 16'hA55A; bus.i_sel = 2'b00;
        step(4);
        chk("lo_e4_data", bus.o_mux_data, 8'h00);
        step(1);
        chk("lo_e5_data", bus.o_mux_data, 8'h5A);
        chk("lo_e5_oe",   {7'd0, bus.o_mux_data_oe}, 8'h00);
        step(1);
        chk("lo_e6_oe",   {7'd0, bus.o_mux_data_oe}, 8'h01);
        step(3);

        // low -> high address byte, enable held
        bus.i_sel = 2'b01;
        step(4);
        chk("hi_e4_data", bus.o_mux_data, 8'h5A);
        step(1);
        chk("hi_e5_data", bus.o_mux_data, 8'hA5);
        chk("hi_e5_oe",   {7'd0, bus.o_mux_data_oe}, 8'h01);
        step(3);

        // data byte follows live source changes
        bus.i_sel = 2'b10; bus.i_cpu_data = 8'h3C;
        step(8);
        chk("data_3c", bus.o_mux_data, 8'h3C);
        bus.i_cpu_data = 8'h77;
        step(1);
        chk("data_77", bus.o_mux_data, 8'h77);
        step(2);

        // driven -> released
        bus.i_sel = 2'b11;
        step(3);
        chk("rel_e3_oe",   {7'd0, bus.o_mux_data_oe}, 8'h01);
        step(1);
        chk("rel_e4_oe",   {7'd0, bus.o_mux_data_oe}, 8'h00);
        chk("rel_e4_data", bus.o_mux_data, 8'h77);
        step(1);
        chk("rel_e5_data", bus.o_mux_data, 8'h00);
        step(3);

        // one-cycle glitch is rejected
        bus.i_sel = 2'b00;
        step(1);
        bus.i_sel = 2'b11;
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk("glitch_oe", {7'd0, bus.o_mux_data_oe}, 8'h00);
        end
        chk("glitch_data", bus.o_mux_data, 8'h00);

        // readback conflict
        bus.i_cpu_addr = 16'hA55A; bus.i_sel = 2'b00;
        step(9);
        chk("cf_drive", bus.o_mux_data, 8'h5A);
        bad = 1;
        step(1);
        bad = 0;
        step(3);
        chk("cf_single", {7'd0, bus.o_bus_conflict}, 8'h00);
        bad = 1;
        step(1);
        chk("cf_first", {7'd0, bus.o_bus_conflict}, 8'h00);
        step(1);
        bad = 0;
        chk("cf_second", {7'd0, bus.o_bus_conflict}, 8'h01);
        step(4);
        chk("cf_sticky", {7'd0, bus.o_bus_conflict}, 8'h01);
        bus.i_sel = 2'b11;
        step(8);
        chk("cf_sticky_rel", {7'd0, bus.o_bus_conflict}, 8'h01);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        chk("cf_cleared", {7'd0, bus.o_bus_conflict}, 8'h00);
        step(3);

        // reset in the middle of a turn-on
        bus.i_sel = 2'b10; bus.i_cpu_data = 8'hC3;
        step(5);
        chk("mid_data", bus.o_mux_data, 8'hC3);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        chk("mid_rst_oe",   {7'd0, bus.o_mux_data_oe}, 8'h00);
        chk("mid_rst_data", bus.o_mux_data, 8'h00);
        step(5);
        chk("mid_again_data", bus.o_mux_data, 8'hC3);
        chk("mid_again_oe",   {7'd0, bus.o_mux_data_oe}, 8'h00);
        step(1);
        chk("mid_again_oe6",  {7'd0, bus.o_mux_data_oe}, 8'h01);
        step(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
